// File: rtl/gray_ctrl.sv
// gray_ctrl: enable sequencer for an external N-bit Gray counter.
// Generates registered one-cycle clk_en pulses:
//   - in bursts of burst_len enables, spaced by period cycles (start)
//   - as a single enable (step)
// Enables are counted in en_cnt. done pulses once when a burst completes.
//
// Optional feature: define GRAY_CTRL_CHECK_EN to build a checker. After every
// enable, the checker verifies that gray_in moved by exactly one bit. A failure
// sets the sticky err flag. Without the macro, err is tied low and no checker
// logic is built.
module gray_ctrl #(
  parameter int N     = 4,
  parameter int DIV_W = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             step,
  input  logic [DIV_W-1:0] period,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [N-1:0]     gray_in,
  output logic             clk_en,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] en_cnt,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [DIV_W-1:0]   period_reg, period_next;
  logic [LEN_W-1:0]   burst_reg, burst_next;
  logic [DIV_W-1:0]   ivl_reg, ivl_next;
  logic [LEN_W-1:0]   en_cnt_reg, en_cnt_next;
  logic               clk_en_reg, clk_en_next;
  logic               done_reg, done_next;
  // Set while the RUN/CHECK pass was entered by step.
  // Such a pass ends after a single enable and does not pulse done.
  logic               one_shot_reg, one_shot_next;

  // Interval reload value. A period of 0 behaves like 1,
  // so the counter never has to wrap below zero.
  function automatic logic [DIV_W-1:0] reload_val(input logic [DIV_W-1:0] p);
    return (p == '0) ? '0 : p - DIV_W'(1);
  endfunction

  // State and datapath registers; asynchronous active-low reset clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      period_reg   <= '0;
      burst_reg    <= '0;
      ivl_reg      <= '0;
      en_cnt_reg   <= '0;
      clk_en_reg   <= 1'b0;
      done_reg     <= 1'b0;
      one_shot_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      period_reg   <= period_next;
      burst_reg    <= burst_next;
      ivl_reg      <= ivl_next;
      en_cnt_reg   <= en_cnt_next;
      clk_en_reg   <= clk_en_next;
      done_reg     <= done_next;
      one_shot_reg <= one_shot_next;
    end
  end

  // Next-state logic.
  // clk_en_next is the decision to fire an enable in the following cycle.
  // en_cnt advances on the same edge that raises clk_en.
  always_comb begin
    state_next    = state_reg;
    period_next   = period_reg;
    burst_next    = burst_reg;
    ivl_next      = ivl_reg;
    en_cnt_next   = en_cnt_reg;
    clk_en_next   = 1'b0;
    done_next     = 1'b0;
    one_shot_next = one_shot_reg;

    if (abort) begin
      // Abort overrides every state and request.
      // No enable is fired and done does not pulse.
      state_next    = IDLE;
      one_shot_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            // The first enable goes out immediately.
            // en_cnt restarts from that enable, so its new value is 1.
            period_next   = period;
            burst_next    = burst_len;
            ivl_next      = reload_val(period);
            en_cnt_next   = LEN_W'(1);
            clk_en_next   = 1'b1;
            one_shot_next = 1'b0;
            state_next    = RUN;
          end else if (step) begin
            en_cnt_next   = en_cnt_reg + LEN_W'(1);
            clk_en_next   = 1'b1;
            one_shot_next = 1'b1;
            state_next    = RUN;
          end
        end

        RUN: begin
          if (one_shot_reg ||
              ((burst_reg != '0) && (en_cnt_reg == burst_reg))) begin
            // The last enable is on clk_en this cycle; wind down through CHECK.
            state_next = CHECK;
          end else if (ivl_reg == '0) begin
            clk_en_next = 1'b1;
            en_cnt_next = en_cnt_reg + LEN_W'(1);
            ivl_next    = reload_val(period_reg);
          end else begin
            ivl_next = ivl_reg - DIV_W'(1);
          end
        end

        CHECK: begin
          state_next    = IDLE;
          done_next     = ~one_shot_reg;
          one_shot_next = 1'b0;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign clk_en = clk_en_reg;
  assign done   = done_reg;
  assign en_cnt = en_cnt_reg;
  assign busy   = (state_reg != IDLE);

`ifdef GRAY_CTRL_CHECK_EN
  logic [N-1:0] cap_reg;
  logic         pend_reg;
  logic         err_reg;
  logic [N-1:0] diff;
  logic         one_bit;

  assign diff    = gray_in ^ cap_reg;
  assign one_bit = (diff != '0) && ((diff & (diff - N'(1))) == '0);

  // Capture the counter value while clk_en is high.
  // In the next cycle, require the value to have moved by exactly one bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_reg  <= '0;
      pend_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      pend_reg <= clk_en_reg;
      if (clk_en_reg) begin
        cap_reg <= gray_in;
      end
      if (pend_reg && !one_bit) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign err = err_reg;
`else
  logic gray_in_unused;
  assign gray_in_unused = ^gray_in;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ctrl.sv
// Testbench for gray_ctrl.
// A table of burst vectors is applied in a loop.
// A scoreboard holds, for each burst, the cycles and Gray values at which
// clk_en is expected; DUT pulses are popped from it and compared.
// Hand-written sequences cover reset, step, start+abort, the Gray checker and
// async reset.
`timescale 1ns/1ps
module tb_gray_ctrl;
  localparam int N     = 4;
  localparam int DIV_W = 8;
  localparam int LEN_W = 8;
`ifdef GRAY_CTRL_CHECK_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             step = 1'b0;
  logic [DIV_W-1:0] period = '0;
  logic [LEN_W-1:0] burst_len = '0;
  logic [N-1:0]     gray_in;
  logic             clk_en, busy, done, err;
  logic [LEN_W-1:0] en_cnt;

  gray_ctrl #(.N(N), .DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .step(step),
    .period(period), .burst_len(burst_len), .gray_in(gray_in),
    .clk_en(clk_en), .busy(busy), .done(done), .en_cnt(en_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Model of the controlled Gray counter, with a clear input and a force
  // override used to inject bad sequences.
  logic [N-1:0] gray_bin;
  logic         gray_clr = 1'b1;
  logic         gray_force = 1'b0;
  logic [N-1:0] gray_force_val = '0;
  always @(posedge clk) begin
    if (gray_clr) gray_bin <= '0;
    else if (clk_en) gray_bin <= gray_bin + 1'b1;
  end
  assign gray_in = gray_force ? gray_force_val : (gray_bin ^ (gray_bin >> 1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] gray_of(input int k);
    logic [N-1:0] b;
    b = k[N-1:0];
    return b ^ (b >> 1);
  endfunction

  typedef struct {
    int period;
    int blen;
    int abort_after;   // 0 = no abort
    int exp_cnt;
    int exp_done;
    int poke;          // drive start/step with other values while busy
    int with_step;     // assert step together with start
  } vec_t;

  typedef struct {
    int           cyc;
    logic [N-1:0] gray;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[9];

  // Apply one burst vector. Must be called aligned to a negative clock edge.
  task automatic run_vec(input vec_t v, input int idx);
    int   pe;
    int   n;
    int   cyc;
    int   seen;
    int   done_cyc;
    int   done_cnt;
    int   budget;
    int   tail_bad;
    exp_t e;
    pe       = (v.period == 0) ? 1 : v.period;
    n        = (v.blen != 0) ? v.blen : v.abort_after;
    budget   = n * pe + 20;
    cyc      = 0;
    seen     = 0;
    done_cyc = -1;
    done_cnt = 0;
    tail_bad = 0;
    sb_q.delete();
    gray_clr = 1'b1;
    @(negedge clk);
    gray_clr = 1'b0;
    for (int k = 0; k < n; k++) begin
      e.cyc  = 1 + k * pe;
      e.gray = gray_of(k);
      sb_q.push_back(e);
    end
    start     = 1'b1;
    period    = v.period[DIV_W-1:0];
    burst_len = v.blen[LEN_W-1:0];
    step      = (v.with_step != 0);
    do begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      step  = 1'b0;
      abort = 1'b0;
      if (cyc == 1) chk("busy_first_run", busy, 1);
      if (clk_en) begin
        seen++;
        chk("sb_nonempty_at_clk_en", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("clk_en_cycle", cyc, e.cyc);
          chk("gray_at_clk_en", gray_in, e.gray);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_without_clk_en", clk_en, 0);
      end
      if (v.poke != 0 && cyc == 2) begin
        start     = 1'b1;
        step      = 1'b1;
        period    = 8'd1;
        burst_len = 8'd9;
      end
      if (v.abort_after != 0 && clk_en && seen == v.abort_after) abort = 1'b1;
    end while ((cyc < 2 || busy) && cyc < budget);
    chk("busy_end", busy, 0);
    chk("pending_enables", sb_q.size(), 0);
    chk("en_cnt", en_cnt, v.exp_cnt);
    if (v.exp_done != 0) chk("done_cycle", done_cyc, 1 + (n - 1) * pe + 2);
    repeat (4) begin
      @(negedge clk);
      if (clk_en) tail_bad++;
      if (done) done_cnt++;
    end
    chk("idle_tail_clk_en", tail_bad, 0);
    chk("done_count", done_cnt, v.exp_done);
    $display("vec %0d: period=%0d burst_len=%0d abort_after=%0d enables=%0d en_cnt=%0d done=%0d",
             idx, v.period, v.blen, v.abort_after, seen, en_cnt, done_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int   cyc;
  int   done_cnt;
  int   bad;
  exp_t e;

  initial begin
    vecs[0] = '{8, 5,   0,  5,   1, 0, 0};
    vecs[1] = '{0, 3,   0,  3,   1, 0, 0};
    vecs[2] = '{1, 1,   0,  1,   1, 0, 0};
    vecs[3] = '{4, 3,   0,  3,   1, 1, 0};
    vecs[4] = '{2, 2,   0,  2,   1, 0, 1};
    vecs[5] = '{4, 0,  10, 10,   0, 0, 0};
    vecs[6] = '{1, 0,   5,  5,   0, 0, 0};
    vecs[7] = '{1, 255, 0,  255, 1, 0, 0};
    vecs[8] = '{3, 4,   0,  4,   1, 0, 0};

    // Reset state
    #1 rst = 1'b0;
    #3;
    chk("reset_clk_en", clk_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_en_cnt", en_cnt, 0);
    chk("reset_err", err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);
    chk("err_after_clean_bursts", err, 0);

    // start and abort together in IDLE: stay idle, en_cnt held
    start = 1'b1; abort = 1'b1; period = 8'd1; burst_len = 8'd3;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_clk_en", clk_en, 0);
    chk("start_abort_en_cnt", en_cnt, vecs[8].exp_cnt);
    $display("start+abort: busy=%0d en_cnt=%0d", busy, en_cnt);

    // Reset, then two steps 10 cycles apart
    rst = 1'b0;
    #1 chk("reset_clears_en_cnt", en_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb_q.delete();
    e.gray = '0;
    e.cyc = 1;  sb_q.push_back(e);
    e.cyc = 11; sb_q.push_back(e);
    step = 1'b1; cyc = 0; done_cnt = 0;
    repeat (16) begin
      @(negedge clk);
      cyc++;
      step = 1'b0;
      if (cyc == 10) step = 1'b1;
      if (clk_en) begin
        chk("step_sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("step_clk_en_cycle", cyc, e.cyc);
        end
      end
      if (done) done_cnt++;
      if (cyc == 2) chk("step_check_busy", busy, 1);
      if (cyc == 3) begin
        chk("step_idle_busy", busy, 0);
        chk("step_en_cnt_1", en_cnt, 1);
      end
    end
    chk("step_pending", sb_q.size(), 0);
    chk("step_en_cnt", en_cnt, 2);
    chk("step_done_count", done_cnt, 0);
    $display("step x2: en_cnt=%0d done_pulses=%0d", en_cnt, done_cnt);

    // Gray checker: 0001 -> 0010 jump after an enable
    gray_force = 1'b1; gray_force_val = 4'b0001; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("chk_clk_en", clk_en, 1);
    @(posedge clk);
    #1 gray_force_val = 4'b0010;
    @(negedge clk);
    chk("chk_err_not_yet", err, 0);
    @(negedge clk);
    chk("chk_err_set", err, EXP_ERR);
    gray_force = 1'b0;
    run_vec(vecs[2], 100);
    chk("chk_err_sticky", err, EXP_ERR);
    $display("gray jump: err=%0d", err);

    // Async reset in the middle of a free-running burst
    start = 1'b1; period = 8'd1; burst_len = 8'd0;
    repeat (6) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_reset_clk_en", clk_en, 1);
    chk("pre_reset_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_clk_en", clk_en, 0);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_done", done, 0);
    chk("async_reset_en_cnt", en_cnt, 0);
    chk("async_reset_err", err, 0);
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (clk_en || busy) bad++;
    end
    chk("no_resume_after_reset", bad, 0);
    $display("async reset: en_cnt=%0d busy=%0d", en_cnt, busy);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gray_ctrl.md
GRAY_CTRL -- requirements
Module: gray_ctrl

Interface
REQ-001 Parameters SHALL be: N, default 4, width of the controlled Gray counter; DIV_W, default 8, period field width; LEN_W, default 8, burst-length and count width.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  level sampled each cycle; begins a burst when in IDLE.
REQ-005 abort  input  1  terminates any activity, returns to IDLE.
REQ-006 step  input  1  requests a single enable when in IDLE.
REQ-007 period  input  DIV_W  cycles between enables; latched on start; 0 treated as 1.
REQ-008 burst_len  input  LEN_W  enables per burst; latched on start; 0 = free-run until abort.
REQ-009 gray_in  input  N  gray_out of the controlled gray_Nbits instance.
REQ-010 clk_en  output  1  clock enable to gray_Nbits; registered, one-cycle pulses.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse on burst completion.
REQ-013 en_cnt  output  LEN_W  number of enables issued since last start; wraps modulo 2^LEN_W.
REQ-014 err  output  1  sticky Gray-sequence error flag (see REQ-031).

Function
REQ-015 FSM states SHALL be IDLE, RUN, CHECK; encoding free.
REQ-016 IDLE + start=1 (abort=0): latch period/burst_len, clear en_cnt, go RUN; clk_en asserted in the first RUN cycle (1 cycle after start sampled).
REQ-017 In RUN, clk_en SHALL assert once every max(period,1) cycles; period=1 gives clk_en high every cycle.
REQ-018 Interval counter SHALL reload to max(period,1)-1 on each enable and decrement to 0; enable issued at 0.
REQ-019 Each clk_en pulse SHALL increment en_cnt by 1 in the same edge.
REQ-020 When en_cnt reaches burst_len (burst_len≠0) on an enable, FSM SHALL go CHECK for exactly one cycle, then IDLE with done=1 in the IDLE-entry cycle.
REQ-021 burst_len=0: RUN continues indefinitely; en_cnt wraps; done never pulses.
REQ-022 IDLE + step=1 (start=0, abort=0): one clk_en next cycle, en_cnt+1, then CHECK, then IDLE; no done pulse.
REQ-023 start and step together in IDLE: start wins.
REQ-024 start and step while busy SHALL be ignored; latched period/burst_len unchanged.
REQ-025 abort=1 in any state SHALL force IDLE at the next edge, clk_en=0 that cycle, no done pulse; abort wins over start/step in the same cycle.
REQ-026 en_cnt SHALL hold its value in IDLE until next start.
REQ-027 done SHALL never coincide with clk_en.
REQ-028 busy SHALL be combinationally derived from state only.

Reset
REQ-029 rst=0 SHALL immediately force: state IDLE, clk_en=0, busy=0, done=0, en_cnt=0, err=0, interval counter 0, latched period/burst_len 0.
REQ-030 Reset release mid-burst SHALL not resume the burst; a new start is required.

Configuration
REQ-031 With macro GRAY_CTRL_CHECK_EN defined: on every clk_en, gray_in SHALL be captured; the following cycle gray_in SHALL differ from the captured value in exactly one bit, else err sets and stays set until reset.
REQ-032 Without GRAY_CTRL_CHECK_EN: no capture register or comparator synthesised; err tied to 0; all other behaviour identical.

Verification
REQ-033 Burst: period=8, burst_len=5, start pulse -> 5 clk_en pulses 8 cycles apart, first 1 cycle after start, en_cnt=5, single done pulse, busy low after.
REQ-034 Back-to-back: period=0, burst_len=3 -> clk_en high 3 consecutive cycles, CHECK, done; gray_in walks 0000,0001,0011,0010.
REQ-035 Abort: period=4, burst_len=0, abort after 10 enables -> IDLE next edge, en_cnt=10, no done, clk_en stays 0.
REQ-036 Step: two step pulses from IDLE 10 cycles apart -> exactly two clk_en, en_cnt=2, done never asserted; start+abort same cycle -> stays IDLE.
REQ-037 Checker (GRAY_CTRL_CHECK_EN): drive gray_in jump 0001->0010 after clk_en -> err=1 next cycle, persists across further bursts until rst=0.
REQ-038 Async reset: assert rst=0 mid-burst between clock edges -> all outputs 0 immediately; after release no clk_en until new start.
